// File: rtl/fifo_pkg.sv
// Shared types, constants and elaboration helpers for the FIFO pointer/status controller.
package fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

    // Status seen after reset and after a flush: nothing stored.
    localparam fifo_status_t FIFO_STATUS_CLR = '{full: 1'b0, empty: 1'b1,
                                                 almost_full: 1'b0, almost_empty: 1'b1};

    function automatic int fifo_aw(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic bit fifo_thresh_ok(input int depth, input int af, input int ae);
        return (depth >= 2) && (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl_if.sv
// Front-end handshake and RAM-side address/status bundle of the FIFO pointer controller.
interface fifo_ptr_ctrl_if #(
    parameter int DEPTH = 16
);
    localparam int AW = fifo_pkg::fifo_aw(DEPTH);

    logic          wen;
    logic          ren;
    logic          flush;
    logic          err_clr;
    logic          wr_ack;
    logic          rd_ack;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;

    modport master (
        output wen, ren, flush, err_clr,
        input  wr_ack, rd_ack, waddr, raddr, count,
        input  full, empty, almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  wen, ren, flush, err_clr,
        output wr_ack, rd_ack, waddr, raddr, count,
        output full, empty, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer; wraps by explicit compare so non-power-of-two depths work.
module fifo_wrap_ptr #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    output logic [AW-1:0] ptr
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
        end
    end
endmodule

// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer, occupancy and status controller: accepts requests, drives RAM
// addresses/enables, and keeps registered flags plus sticky error flags.
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    fifo_ptr_ctrl_if.slave    bus
);
    localparam int AW = fifo_aw(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_AF   = (AW + 1)'(AF_THRESH);
    localparam logic [AW:0] CNT_AE   = (AW + 1)'(AE_THRESH);

    if (!fifo_thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
        $error("fifo_ptr_ctrl: DEPTH/AF_THRESH/AE_THRESH out of legal range");
    end

    logic          rd_ok;
    logic          wr_ok;
    logic [AW:0]   count_q;
    logic [AW:0]   count_nxt;
    fifo_status_t  status_q;
    fifo_status_t  status_nxt;
    logic          overflow_q;
    logic          underflow_q;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    // A write into a full FIFO is legal only when a read frees a slot in the same cycle.
    assign rd_ok = bus.ren & ~status_q.empty & ~bus.flush;
    assign wr_ok = bus.wen & ~bus.flush & (~status_q.full | rd_ok);

    fifo_wrap_ptr #(.DEPTH(DEPTH), .AW(AW)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wr_ok),
        .clr   (bus.flush),
        .ptr   (wptr)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH), .AW(AW)) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rd_ok),
        .clr   (bus.flush),
        .ptr   (rptr)
    );

    always_comb begin
        count_nxt = count_q;
        if (bus.flush) begin
            count_nxt = '0;
        end else if (wr_ok && !rd_ok) begin
            count_nxt = count_q + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_nxt = count_q - 1'b1;
        end

        status_nxt              = FIFO_STATUS_CLR;
        status_nxt.full         = (count_nxt == CNT_FULL);
        status_nxt.empty        = (count_nxt == '0);
        status_nxt.almost_full  = (count_nxt >= CNT_AF);
        status_nxt.almost_empty = (count_nxt <= CNT_AE);
    end

    // Error set takes priority over err_clr so a same-cycle event is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            status_q    <= FIFO_STATUS_CLR;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q  <= count_nxt;
            status_q <= bus.flush ? FIFO_STATUS_CLR : status_nxt;
            if (bus.wen && !wr_ok && !bus.flush) begin
                overflow_q <= 1'b1;
            end else if (bus.err_clr) begin
                overflow_q <= 1'b0;
            end
            if (bus.ren && !rd_ok && !bus.flush) begin
                underflow_q <= 1'b1;
            end else if (bus.err_clr) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign bus.wr_ack       = wr_ok;
    assign bus.rd_ack       = rd_ok;
    assign bus.waddr        = wptr;
    assign bus.raddr        = rptr;
    assign bus.count        = count_q;
    assign bus.full         = status_q.full;
    assign bus.empty        = status_q.empty;
    assign bus.almost_full  = status_q.almost_full;
    assign bus.almost_empty = status_q.almost_empty;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: doc/fifo_ptr_ctrl.md
# fifo_ptr_ctrl

Parametrised pointer and status controller for the synchronous FIFO. It replaces the separate fixed-width write and read pointer counters with one block. The block supports any integer depth, including non-power-of-two, and accepts a write on a full FIFO when a read is accepted in the same cycle. It also provides an occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. It sits between the FIFO front-end handshake and the dual-port storage array, supplying addresses and write/read enables.

## Interface
- DEPTH, 16: number of entries; any integer ≥ 2.
- AW, $clog2(DEPTH): address width; derived, not overridden.
- AF_THRESH, DEPTH-2: almost_full asserts when count ≥ AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2: almost_empty asserts when count ≤ AE_THRESH; legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- wen  in  1  write request.
- ren  in  1  read request.
- flush  in  1  synchronous clear of pointers and count.
- err_clr  in  1  clears the sticky error flags.
- wr_ack  out  1  write accepted this cycle; drives the RAM write enable.
- rd_ack  out  1  read accepted this cycle; drives the RAM read enable.
- waddr  out  AW  RAM write address (current write pointer).
- raddr  out  AW  RAM read address (current read pointer).
- count  out  AW+1  occupancy, 0..DEPTH.
- full, empty, almost_full, almost_empty  out  1 each  status flags.
- overflow, underflow  out  1 each  sticky error flags.

## Operation
- Read acceptance: rd_ok = ren & ~empty & ~flush.
- Write acceptance: wr_ok = wen & ~flush & (~full | rd_ok). A write on a full FIFO is accepted only alongside an accepted read.
- No bypass when empty: a read on an empty FIFO is refused even if a write is accepted in the same cycle.
- wr_ack and rd_ack are combinational copies of wr_ok and rd_ok.
- waddr and raddr are the registered pointers, with no combinational path from the inputs.
- Pointer advance: each pointer advances by 1 on its accept. The value DEPTH-1 wraps to 0 by explicit compare, never by natural binary overflow.
- Count update: +1 on wr_ok & ~rd_ok; -1 on rd_ok & ~wr_ok; unchanged when both or neither are accepted.
- Flags are registered from the next count:
  - full = (count == DEPTH)
  - empty = (count == 0)
  - almost_full = (count ≥ AF_THRESH)
  - almost_empty = (count ≤ AE_THRESH)
- overflow sets when wen & ~wr_ok & ~flush.
- underflow sets when ren & ~rd_ok & ~flush.
- Error flags hold until err_clr. If a set and err_clr occur in the same cycle, the set wins.
- flush, next edge: both pointers 0, count 0, empty 1, almost_empty 1, full 0, almost_full 0. Acks are 0 during the flush cycle. Error flags are unaffected by flush.
- Reset (async assert, any time, including mid-transfer): pointers 0, count 0, empty 1, almost_empty 1, full 0, almost_full 0, overflow 0, underflow 0. With no requests, wr_ack and rd_ack are 0.

## Timing
- Acks respond in the same cycle as the request (combinational).
- Pointers, count and flags update on the edge that ends an accepted cycle, so the status reflects the transfer one cycle later.
- The RAM captures write data at waddr on the edge where wr_ack = 1. The read-data latency belongs to the RAM, not this block.
- Simultaneous read and write at count = DEPTH: both are accepted, count stays DEPTH and both pointers advance.
- Simultaneous read and write at count = 0: only the write is accepted, and count becomes 1.
- Flush has priority over wen and ren. Reset has priority over everything.

## Structure
- Package fifo_pkg holds:
  - the function computing AW from DEPTH;
  - the flush/reset status constants (empty=1, almost_empty=1, full=0, almost_full=0);
  - an elaboration check that AF_THRESH and AE_THRESH are within their legal ranges.
- One sub-module, fifo_wrap_ptr (parameters DEPTH, AW; inputs inc and clr; output ptr), instantiated twice, once for the write pointer and once for the read pointer.
- Count, flag and error logic sit in the top level.

## Test plan
- Non-power-of-two fill: DEPTH=6, AF_THRESH=4, AE_THRESH=1; write 6 with no reads.
  - waddr goes 0..5, then wraps to 0.
  - count reaches 6, full=1.
  - almost_full asserts after the 4th write; almost_empty deasserts after the 2nd write.
- Overflow: at full, wen=1 with ren=0.
  - wr_ack=0, overflow=1 on the next cycle, count stays 6.
  - err_clr clears overflow one cycle later.
- Full pass-through: at full, wen=1 and ren=1.
  - wr_ack=1 and rd_ack=1.
  - count stays 6, both pointers advance by 1 with wrap.
- Empty corner: at empty, wen=1 and ren=1.
  - wr_ack=1 and rd_ack=0; underflow=1, count becomes 1.
  - err_clr asserted in the same cycle as a new underflow leaves underflow=1.
- Flush mid-stream: count=3, flush=1 together with wen=1 and ren=1.
  - Both acks are 0.
  - Next cycle: pointers 0, count 0, empty=1; error flags unchanged.
- Async reset mid-operation: assert rst_n=0 between edges while count=5.
  - All outputs take their reset values immediately.
  - After release, the first write uses waddr=0.
